// File: rtl/fp_normalize_round.sv
// fp_normalize_round: post-add normalise / round stage of the FP adder.
// Three register stages (capture+LZC, normalise, round+pack) sharing one
// advance enable derived from the output handshake.
// Optional feature macro: FP_NORM_ROUND_EN (defined -> round-to-nearest-even,
// undefined -> truncate).
module fp_normalize_round #(
  parameter int WIDTH     = 24,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_WIDTH-1:0] in_exp,
  input  logic [WIDTH+2:0]     in_mant,
  input  logic                 in_sticky,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic [WIDTH-2:0]     out_frac,
  output logic                 out_zero,
  output logic                 out_overflow,
  output logic                 out_underflow
);

  localparam int VW  = WIDTH + 2;
  localparam int LZW = $clog2(VW + 1);
  localparam int EW1 = EXP_WIDTH + 1;
  localparam int CW  = ((LZW > EXP_WIDTH) ? LZW : EXP_WIDTH) + 1;
  localparam logic [EW1-1:0] EXP_MAX = {1'b0, {EXP_WIDTH{1'b1}}};

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic [EXP_WIDTH-1:0] exp;
    logic                 carry;
    logic [VW-1:0]        vec;
    logic                 sticky;
    logic [LZW-1:0]       lzc;
    logic                 all_zero;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [EW1-1:0]   exp;
    logic [WIDTH-1:0] mant;
    logic             g;
    logic             r;
    logic             s;
    logic             zero;
    logic             underflow;
  } s2_t;

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic [EXP_WIDTH-1:0] exp;
    logic [WIDTH-2:0]     frac;
    logic                 zero;
    logic                 overflow;
    logic                 underflow;
  } out_t;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  out_t out_q, out_d;

  logic           adv;
  logic [LZW-1:0] lzc;
  logic [VW-1:0]  shifted;
  logic [WIDTH-1:0] mant_r;
  logic [EW1-1:0]   exp_r;
  logic             unused_bits;

  assign adv      = out_ready | ~out_q.valid;
  assign in_ready = adv;

  // Leading-zero count of {mant,guard,round}; the highest set bit wins.
  always_comb begin
    lzc = LZW'(VW);
    for (int unsigned i = 0; i < VW; i++) begin
      if (in_mant[i]) lzc = LZW'(VW - 1 - i);
    end
  end

  // Stage 1: capture the beat together with its LZC.
  always_comb begin
    s1_d = s1_q;
    if (adv) begin
      s1_d.valid    = in_valid;
      s1_d.sign     = in_sign;
      s1_d.exp      = in_exp;
      s1_d.carry    = in_mant[WIDTH+2];
      s1_d.vec      = in_mant[VW-1:0];
      s1_d.sticky   = in_sticky;
      s1_d.lzc      = lzc;
      s1_d.all_zero = (in_mant[VW-1:0] == '0);
    end
  end

  // Stage 2: normalise (carry right-shift, LZC left-shift, zero/underflow).
  always_comb begin
    s2_d    = s2_q;
    shifted = s1_q.vec << s1_q.lzc;
    if (adv) begin
      s2_d.valid     = s1_q.valid;
      s2_d.sign      = s1_q.sign;
      s2_d.exp       = '0;
      s2_d.mant      = '0;
      s2_d.g         = 1'b0;
      s2_d.r         = 1'b0;
      s2_d.s         = 1'b0;
      s2_d.zero      = 1'b0;
      s2_d.underflow = 1'b0;
      if (s1_q.carry) begin
        s2_d.mant = {1'b1, s1_q.vec[VW-1:3]};
        s2_d.g    = s1_q.vec[2];
        s2_d.r    = s1_q.vec[1];
        s2_d.s    = s1_q.vec[0] | s1_q.sticky;
        s2_d.exp  = {1'b0, s1_q.exp} + EW1'(1);
      end else if (s1_q.all_zero) begin
        s2_d.zero = 1'b1;
      end else if (CW'(s1_q.lzc) >= CW'(s1_q.exp)) begin
        s2_d.zero      = 1'b1;
        s2_d.underflow = 1'b1;
      end else begin
        s2_d.mant = shifted[VW-1:2];
        s2_d.g    = shifted[1];
        s2_d.r    = shifted[0];
        s2_d.s    = s1_q.sticky;
        s2_d.exp  = {1'b0, s1_q.exp} - EW1'(s1_q.lzc);
      end
    end
  end

  // Stage 3: round, re-normalise on round carry, saturate and pack.
  always_comb begin
    out_d  = out_q;
    mant_r = s2_q.mant;
    exp_r  = s2_q.exp;
`ifdef FP_NORM_ROUND_EN
    begin
      logic             up;
      logic [WIDTH:0]   sum;
      up  = s2_q.g & (s2_q.r | s2_q.s | s2_q.mant[0]);
      sum = {1'b0, s2_q.mant} + (WIDTH+1)'(up);
      if (sum[WIDTH]) begin
        mant_r = {1'b1, {(WIDTH-1){1'b0}}};
        exp_r  = s2_q.exp + EW1'(1);
      end else begin
        mant_r = sum[WIDTH-1:0];
      end
    end
`endif
    if (adv) begin
      out_d.valid     = s2_q.valid;
      out_d.sign      = s2_q.sign & ~s2_q.zero;
      out_d.zero      = s2_q.zero;
      out_d.underflow = s2_q.underflow;
      out_d.overflow  = 1'b0;
      if (s2_q.zero) begin
        out_d.exp  = '0;
        out_d.frac = '0;
      end else if (exp_r >= EXP_MAX) begin
        out_d.overflow = 1'b1;
        out_d.exp      = '1;
        out_d.frac     = '0;
      end else begin
        out_d.exp  = exp_r[EXP_WIDTH-1:0];
        out_d.frac = mant_r[WIDTH-2:0];
      end
    end
  end

  // Hidden bit is dropped; G/R/S only feed rounding when it is enabled.
`ifdef FP_NORM_ROUND_EN
  assign unused_bits = mant_r[WIDTH-1];
`else
  assign unused_bits = ^{mant_r[WIDTH-1], s2_q.g, s2_q.r, s2_q.s};
`endif

  // Pipeline registers; reset clears valids and every output field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
    end
  end

  assign out_valid     = out_q.valid;
  assign out_sign      = out_q.sign;
  assign out_exp       = out_q.exp;
  assign out_frac      = out_q.frac;
  assign out_zero      = out_q.zero;
  assign out_overflow  = out_q.overflow;
  assign out_underflow = out_q.underflow;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round: directed vectors push expected
// results; an independent monitor pops and compares on each output transfer.
module tb_fp_normalize_round;
  localparam int WIDTH     = 24;
  localparam int EXP_WIDTH = 8;
`ifdef FP_NORM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [26:0] in_mant = '0;
  logic        in_sticky = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_zero;
  logic        out_overflow;
  logic        out_underflow;

  fp_normalize_round #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [34:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [34:0] pk(logic s, logic [7:0] e, logic [22:0] f,
                                     logic z, logic o, logic u);
    return {s, e, f, z, o, u};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  logic [34:0] cur;
  assign cur = pk(out_sign, out_exp, out_frac, out_zero, out_overflow, out_underflow);

  // Monitor: compares transfers, checks stall behaviour and output stability.
  logic        stalled_prev = 1'b0;
  logic [34:0] held = '0;
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) check("hold", {out_valid, cur}, {1'b1, held});
      if (out_valid && !out_ready) begin
        check("in_ready_stall", in_ready, 0);
        stalled_prev = 1'b1;
        held = cur;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h, expected no output", cur);
        end else begin
          e = sb.pop_front();
          check(e.name, cur, e.val);
        end
      end
    end
  end

  task automatic send(string name, logic s, logic [7:0] e, logic [26:0] m,
                      logic st, logic [34:0] expv);
    int unsigned n = 0;
    logic acc;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_sticky = st;
    while (1) begin
      #1 acc = in_ready;
      if (acc) sb.push_back('{name, expv});
      @(posedge clk);
      if (acc) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout_%s: got in_ready=0, expected 1 within 50 cycles", name);
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    int unsigned n;
    int unsigned seen;

    repeat (3) @(negedge clk);
    check("rst_outputs", {out_valid, out_sign, out_exp, out_frac, out_zero,
                          out_overflow, out_underflow}, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Directed vectors, back to back
    send("carry_norm", 0, 8'd127, {1'b1, 24'h800000, 2'b00}, 0, pk(0, 8'd128, 23'h400000, 0, 0, 0));
    send("tie_odd",    0, 8'd127, {1'b0, 24'h800001, 2'b10}, 0, pk(0, 8'd127, RND ? 23'h000002 : 23'h000001, 0, 0, 0));
    send("tie_even",   0, 8'd127, {1'b0, 24'h800000, 2'b10}, 0, pk(0, 8'd127, 23'h0, 0, 0, 0));
    send("lshift11",   0, 8'd20,  {1'b0, 24'h001234, 2'b00}, 0, pk(0, 8'd9, 23'h11A000, 0, 0, 0));
    send("uflow_eq",   1, 8'd11,  {1'b0, 24'h001234, 2'b00}, 0, pk(0, 8'd0, 23'h0, 1, 0, 1));
    send("lshift_lt",  1, 8'd12,  {1'b0, 24'h001234, 2'b00}, 0, pk(1, 8'd1, 23'h11A000, 0, 0, 0));
    send("rnd_ovf",    0, 8'd254, {1'b0, 24'hFFFFFF, 2'b11}, 0,
         RND ? pk(0, 8'hFF, 23'h0, 0, 1, 0) : pk(0, 8'hFE, 23'h7FFFFF, 0, 0, 0));
    send("all_zero",   1, 8'd100, {1'b0, 24'h000000, 2'b00}, 1, pk(0, 8'd0, 23'h0, 1, 0, 0));
    send("carry_rnd",  0, 8'd100, {1'b1, 24'h800003, 2'b00}, 0,
         pk(0, 8'd101, RND ? 23'h400002 : 23'h400001, 0, 0, 0));
    send("carry_ovf",  0, 8'd254, {1'b1, 24'h800000, 2'b00}, 0, pk(0, 8'hFF, 23'h0, 0, 1, 0));
    send("lshift25",   0, 8'd30,  {1'b0, 24'h000000, 2'b01}, 0, pk(0, 8'd5, 23'h0, 0, 0, 0));
    send("rnd_carry",  0, 8'd100, {1'b0, 24'hFFFFFF, 2'b10}, 1,
         RND ? pk(0, 8'd101, 23'h0, 0, 0, 0) : pk(0, 8'd100, 23'h7FFFFF, 0, 0, 0));
    send("sticky_up",  0, 8'd127, {1'b0, 24'h800000, 2'b10}, 1, pk(0, 8'd127, RND ? 23'h000001 : 23'h0, 0, 0, 0));
    drain();

    // Latency with out_ready high
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = {1'b1, 24'h800000, 2'b00}; in_sticky = 1'b0;
    sb.push_back('{"latency_beat", pk(0, 8'd128, 23'h400000, 0, 0, 0)});
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", lat, 3);
    drain();

    // Stall: 4 beats streamed while out_ready is held low for 3 cycles
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        send("st_a", 0, 8'd20,  {1'b0, 24'h001234, 2'b00}, 0, pk(0, 8'd9, 23'h11A000, 0, 0, 0));
        send("st_b", 0, 8'd127, {1'b0, 24'h800001, 2'b10}, 0, pk(0, 8'd127, RND ? 23'h000002 : 23'h000001, 0, 0, 0));
        send("st_c", 1, 8'd50,  {1'b0, 24'h000000, 2'b00}, 0, pk(0, 8'd0, 23'h0, 1, 0, 0));
        send("st_d", 0, 8'd254, {1'b1, 24'h800000, 2'b00}, 0, pk(0, 8'hFF, 23'h0, 0, 1, 0));
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    send("rs_a", 0, 8'd127, {1'b1, 24'h800000, 2'b00}, 0, pk(0, 8'd128, 23'h400000, 0, 0, 0));
    send("rs_b", 0, 8'd20,  {1'b0, 24'h001234, 2'b00}, 0, pk(0, 8'd9, 23'h11A000, 0, 0, 0));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_in_flight", out_valid, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post_rst_silent", seen, 0);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
